// File: rtl/dwc_mon_pkg.sv
// Shared types and constants for the DWC fault monitor: FSM encoding,
// status word bit positions and the consecutive-miss counter width.
package dwc_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RETRY = 2'd1,
    ST_FAULT = 2'd2
  } mon_state_e;

  localparam int CONSEC_W = 8;

  localparam int STAT_RETRY_BIT   = 0;
  localparam int STAT_FAULT_BIT   = 1;
  localparam int STAT_MATCH_BIT   = 2;
  localparam int STAT_DROP_BIT    = 3;
  localparam int STAT_SAT_BIT     = 4;
  localparam int STAT_STATE_LSB   = 5;
  localparam int STAT_STATE_MSB   = 6;
  localparam int STAT_CONSEC_LSB  = 8;
  localparam int STAT_CONSEC_MSB  = 15;

endpackage

// File: rtl/dwc_sat_counter.sv
// Saturating up-counter with a sticky saturation flag; clear beats increment.
module dwc_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  logic [W-1:0] count_q, count_d;
  logic         sat_q, sat_d;

  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clr) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (inc) begin
      // At all-ones the count holds; the attempted increment is what marks saturation.
      if (&count_q) sat_d = 1'b1;
      else          count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/dwc_fault_monitor.sv
// Turns DWC comparator done/isMatch levels into counted events, requests a
// rollback on mismatch and latches a permanent fault after too many in a row.
module dwc_fault_monitor
  import dwc_mon_pkg::*;
#(
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmp_done,
  input  logic             cmp_match,
  input  logic             retry_ack,
  input  logic             clr_fault,
  input  logic             clr_cnt,
  output logic             retry_req,
  output logic             fault_perm,
  output logic             irq,
  output logic [31:0]      status,
  output logic [CNT_W-1:0] cmp_total,
  output logic [CNT_W-1:0] mismatch_total
);

  localparam logic [CONSEC_W-1:0] MAX_RETRY_V = CONSEC_W'(MAX_RETRY);
  localparam logic [CONSEC_W-1:0] CONSEC_ONE  = CONSEC_W'(1);

  mon_state_e          state_q, state_d;
  logic [CONSEC_W-1:0] consec_q, consec_d;
  logic                done_q, done_d;
  logic                last_match_q, last_match_d;
  logic                dropped_q, dropped_d;
  logic                retry_req_q, retry_req_d;
  logic                fault_perm_q, fault_perm_d;
  logic                irq_q, irq_d;
  logic                evt, cnt_inc, mis_inc;
  logic                cmp_sat, mis_sat;

  // done is a level held until ack, so only its rising edge is an event.
  assign evt    = cmp_done & ~done_q;
  assign done_d = cmp_done;

  always_comb begin
    state_d      = state_q;
    consec_d     = consec_q;
    last_match_d = last_match_q;
    dropped_d    = dropped_q;
    cnt_inc      = 1'b0;
    mis_inc      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (evt) begin
          cnt_inc      = 1'b1;
          last_match_d = cmp_match;
          if (cmp_match) begin
            consec_d = '0;
          end else begin
            mis_inc  = 1'b1;
            consec_d = consec_q + CONSEC_ONE;
            state_d  = (consec_d > MAX_RETRY_V) ? ST_FAULT : ST_RETRY;
          end
        end
      end
      ST_RETRY: begin
        if (evt)       dropped_d = 1'b1;
        if (retry_ack) state_d   = ST_IDLE;
      end
      ST_FAULT: begin
        if (evt) dropped_d = 1'b1;
        if (clr_fault) begin
          state_d  = ST_IDLE;
          consec_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr_cnt) dropped_d = 1'b0;
    retry_req_d  = (state_d == ST_RETRY);
    fault_perm_d = (state_d == ST_FAULT);
    irq_d        = retry_req_d | fault_perm_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      consec_q     <= '0;
      done_q       <= 1'b0;
      last_match_q <= 1'b0;
      dropped_q    <= 1'b0;
      retry_req_q  <= 1'b0;
      fault_perm_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      consec_q     <= consec_d;
      done_q       <= done_d;
      last_match_q <= last_match_d;
      dropped_q    <= dropped_d;
      retry_req_q  <= retry_req_d;
      fault_perm_q <= fault_perm_d;
      irq_q        <= irq_d;
    end
  end

  dwc_sat_counter #(.W(CNT_W)) u_cmp_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (cnt_inc),
    .clr   (clr_cnt),
    .count (cmp_total),
    .sat   (cmp_sat)
  );

  dwc_sat_counter #(.W(CNT_W)) u_mis_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (mis_inc),
    .clr   (clr_cnt),
    .count (mismatch_total),
    .sat   (mis_sat)
  );

  always_comb begin
    status                                   = '0;
    status[STAT_RETRY_BIT]                   = retry_req_q;
    status[STAT_FAULT_BIT]                   = fault_perm_q;
    status[STAT_MATCH_BIT]                   = last_match_q;
    status[STAT_DROP_BIT]                    = dropped_q;
    status[STAT_SAT_BIT]                     = cmp_sat | mis_sat;
    status[STAT_STATE_MSB:STAT_STATE_LSB]    = state_q;
    status[STAT_CONSEC_MSB:STAT_CONSEC_LSB]  = consec_q;
  end

  assign retry_req  = retry_req_q;
  assign fault_perm = fault_perm_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_dwc_fault_monitor.sv
// Directed bench for dwc_fault_monitor: a vector table for the main protocol
// plus hand-written reset, MAX_RETRY=0 and counter saturation sequences.
module tb_dwc_fault_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cmp_done, cmp_match, retry_ack, clr_fault, clr_cnt;
  logic        retry_req, fault_perm, irq;
  logic [31:0] status;
  logic [7:0]  cmp_total, mismatch_total;

  logic        cmp_done_z, cmp_match_z, retry_ack_z, clr_fault_z, clr_cnt_z;
  logic        retry_req_z, fault_perm_z, irq_z;
  logic [31:0] status_z;
  logic [15:0] cmp_total_z, mismatch_total_z;

  dwc_fault_monitor #(.MAX_RETRY(3), .CNT_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmp_done       (cmp_done),
    .cmp_match      (cmp_match),
    .retry_ack      (retry_ack),
    .clr_fault      (clr_fault),
    .clr_cnt        (clr_cnt),
    .retry_req      (retry_req),
    .fault_perm     (fault_perm),
    .irq            (irq),
    .status         (status),
    .cmp_total      (cmp_total),
    .mismatch_total (mismatch_total)
  );

  dwc_fault_monitor #(.MAX_RETRY(0), .CNT_W(16)) dut_z (
    .clk            (clk),
    .reset          (reset),
    .cmp_done       (cmp_done_z),
    .cmp_match      (cmp_match_z),
    .retry_ack      (retry_ack_z),
    .clr_fault      (clr_fault_z),
    .clr_cnt        (clr_cnt_z),
    .retry_req      (retry_req_z),
    .fault_perm     (fault_perm_z),
    .irq            (irq_z),
    .status         (status_z),
    .cmp_total      (cmp_total_z),
    .mismatch_total (mismatch_total_z)
  );

  typedef struct {
    logic        done;
    logic        match;
    logic        ack;
    logic        clrf;
    logic        clrc;
    logic [31:0] exp_st;
    logic [7:0]  exp_cmp;
    logic [7:0]  exp_mis;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [31:0] st(input logic rr, input logic fp, input logic lm,
                                     input logic dr, input logic sat,
                                     input logic [1:0] s, input logic [7:0] cm);
    return {16'h0, cm, 1'b0, s, sat, dr, lm, fp, rr};
  endfunction

  function automatic void add(input logic d, input logic m, input logic a,
                              input logic cf, input logic cc, input logic [31:0] es,
                              input logic [7:0] ec, input logic [7:0] em);
    vec_t v;
    v.done = d; v.match = m; v.ack = a; v.clrf = cf; v.clrc = cc;
    v.exp_st = es; v.exp_cmp = ec; v.exp_mis = em;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic d, input logic m, input logic a,
                       input logic cf, input logic cc);
    cmp_done = d; cmp_match = m; retry_ack = a; clr_fault = cf; clr_cnt = cc;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic [31:0] es,
                          input logic [7:0] ec, input logic [7:0] em);
    chk({tag, " status"},     status, es);
    chk({tag, " cmp_total"},  32'(cmp_total), 32'(ec));
    chk({tag, " mis_total"},  32'(mismatch_total), 32'(em));
    chk({tag, " retry_req"},  32'(retry_req), 32'(es[0]));
    chk({tag, " fault_perm"}, 32'(fault_perm), 32'(es[1]));
    chk({tag, " irq"},        32'(irq), 32'(es[0] | es[1]));
  endtask

  task automatic pulse_evt(input logic m, input logic cc);
    drive(1'b1, m, 1'b0, 1'b0, cc);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp_done_z = 1'b0; cmp_match_z = 1'b0; retry_ack_z = 1'b0;
    clr_fault_z = 1'b0; clr_cnt_z = 1'b0;

    // Three match events, done held 4 cycles each.
    for (int e = 1; e <= 3; e++) begin
      for (int k = 0; k < 4; k++) add(1, 1, 0, 0, 0, st(0,0,1,0,0,2'd0,8'd0), 8'(e), 8'd0);
      add(0, 0, 0, 0, 0, st(0,0,1,0,0,2'd0,8'd0), 8'(e), 8'd0);
    end
    // Three mismatch/ack rounds, then the fatal fourth mismatch.
    for (int k = 1; k <= 3; k++) begin
      add(1, 0, 0, 0, 0, st(1,0,0,0,0,2'd1,8'(k)), 8'(3 + k), 8'(k));
      add(0, 0, 0, 0, 0, st(1,0,0,0,0,2'd1,8'(k)), 8'(3 + k), 8'(k));
      add(0, 0, 1, 0, 0, st(0,0,0,0,0,2'd0,8'(k)), 8'(3 + k), 8'(k));
    end
    add(1, 0, 0, 0, 0, st(0,1,0,0,0,2'd2,8'd4), 8'd7, 8'd4);
    add(0, 0, 0, 0, 0, st(0,1,0,0,0,2'd2,8'd4), 8'd7, 8'd4);
    // Events in FAULT are dropped; clr_fault returns to IDLE.
    add(1, 0, 0, 0, 0, st(0,1,0,1,0,2'd2,8'd4), 8'd7, 8'd4);
    add(0, 0, 0, 0, 0, st(0,1,0,1,0,2'd2,8'd4), 8'd7, 8'd4);
    add(1, 1, 0, 0, 0, st(0,1,0,1,0,2'd2,8'd4), 8'd7, 8'd4);
    add(0, 0, 0, 0, 0, st(0,1,0,1,0,2'd2,8'd4), 8'd7, 8'd4);
    add(0, 0, 0, 1, 0, st(0,0,0,1,0,2'd0,8'd0), 8'd7, 8'd4);
    add(1, 1, 0, 0, 0, st(0,0,1,1,0,2'd0,8'd0), 8'd8, 8'd4);
    add(0, 0, 0, 0, 0, st(0,0,1,1,0,2'd0,8'd0), 8'd8, 8'd4);
    // clr_cnt, then an event coincident with retry_ack in RETRY.
    add(0, 0, 0, 0, 1, st(0,0,1,0,0,2'd0,8'd0), 8'd0, 8'd0);
    add(1, 0, 0, 0, 0, st(1,0,0,0,0,2'd1,8'd1), 8'd1, 8'd1);
    add(0, 0, 0, 0, 0, st(1,0,0,0,0,2'd1,8'd1), 8'd1, 8'd1);
    add(1, 1, 1, 0, 0, st(0,0,0,1,0,2'd0,8'd1), 8'd1, 8'd1);
    add(0, 0, 0, 0, 0, st(0,0,0,1,0,2'd0,8'd1), 8'd1, 8'd1);
    // clr_cnt on an event edge: counters clear, FSM still takes the mismatch.
    add(1, 0, 0, 0, 1, st(1,0,0,0,0,2'd1,8'd2), 8'd0, 8'd0);
    add(0, 0, 0, 0, 0, st(1,0,0,0,0,2'd1,8'd2), 8'd0, 8'd0);
    add(0, 0, 1, 0, 0, st(0,0,0,0,0,2'd0,8'd2), 8'd0, 8'd0);
    // Stray ack / clr_fault in IDLE are ignored.
    add(0, 0, 1, 0, 0, st(0,0,0,0,0,2'd0,8'd2), 8'd0, 8'd0);
    add(0, 0, 0, 1, 0, st(0,0,0,0,0,2'd0,8'd2), 8'd0, 8'd0);

    repeat (3) cyc();
    chk_main("in_reset", 32'h0, 8'd0, 8'd0);
    reset = 1'b1;
    cyc();
    chk_main("post_reset", 32'h0, 8'd0, 8'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].done, vecs[i].match, vecs[i].ack, vecs[i].clrf, vecs[i].clrc);
      cyc();
      chk_main($sformatf("vec%0d", i), vecs[i].exp_st, vecs[i].exp_cmp, vecs[i].exp_mis);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // MAX_RETRY=0: first mismatch is fatal, retry_req never asserts.
    chk("z idle status", status_z, 32'h0);
    cmp_done_z = 1'b1; cmp_match_z = 1'b0;
    cyc();
    chk("z retry_req", 32'(retry_req_z), 32'h0);
    chk("z fault_perm", 32'(fault_perm_z), 32'h1);
    chk("z irq", 32'(irq_z), 32'h1);
    chk("z status", status_z, 32'h0000_0142);
    chk("z mis_total", 32'(mismatch_total_z), 32'h1);
    cmp_done_z = 1'b0;
    cyc();

    // Reset asserted mid-RETRY with counters at 5.
    repeat (4) pulse_evt(1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk_main("pre_rst", st(1,0,0,0,0,2'd1,8'd1), 8'd5, 8'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk_main("async_rst", 32'h0, 8'd0, 8'd0);
    chk("async_rst z status", status_z, 32'h0);
    cyc();
    cyc();
    chk_main("held_rst", 32'h0, 8'd0, 8'd0);
    reset = 1'b1;
    cyc();
    chk_main("rst_release", 32'h0, 8'd0, 8'd0);

    // 8-bit saturation with and without a coincident clr_cnt.
    for (int pass = 0; pass < 2; pass++) begin
      repeat (255) pulse_evt(1'b1, 1'b0);
      chk_main($sformatf("sat%0d_255", pass), st(0,0,1,0,0,2'd0,8'd0), 8'd255, 8'd0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, (pass == 0) ? 1'b1 : 1'b0);
      cyc();
      if (pass == 0) chk_main("sat0_clr", st(0,0,1,0,0,2'd0,8'd0), 8'd0, 8'd0);
      else           chk_main("sat1_hold", st(0,0,1,0,1,2'd0,8'd0), 8'd255, 8'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
